// File: rtl/ppu_line_buf.sv
// ---------------------------------------------------------------------------
// ppu_line_buf
//
// Double-buffered scanline store between the NES renderer and the VGA output
// stage. The VGA stage reads the front bank by NES x coordinate while the
// renderer fills the back bank with the next scanline. Every change of the
// VGA stage's NES y coordinate swaps the banks and asks the renderer for the
// following line.
//
// Ports
//   clk_in              : system clock, all state changes on its rising edge
//   rst_in              : asynchronous active-high reset
//   nes_x_in            : current NES x coordinate (display read address)
//   nes_y_in            : current NES y coordinate (line change detection)
//   wr_en_in            : renderer pixel-write strobe, one pixel per cycle
//   wr_idx_in           : renderer pixel value (system palette index)
//   clr_underrun_in     : clears the sticky underrun flag
//   sys_palette_idx_out : palette index of the displayed pixel
//   fill_req_out        : one-cycle pulse, renderer starts line fill_y_out
//   fill_y_out          : scanline the renderer produces next
//   fill_busy_out       : high while the back bank accepts writes
//   underrun_out        : sticky, a swap happened before a fill completed
// ---------------------------------------------------------------------------
module ppu_line_buf #(
    parameter int NES_W = 256,
    parameter int NES_H = 240
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] nes_x_in,
    input  logic [9:0] nes_y_in,
    input  logic       wr_en_in,
    input  logic [5:0] wr_idx_in,
    input  logic       clr_underrun_in,
    output logic [5:0] sys_palette_idx_out,
    output logic       fill_req_out,
    output logic [9:0] fill_y_out,
    output logic       fill_busy_out,
    output logic       underrun_out
);

    localparam int            AW       = $clog2(NES_W);
    localparam logic [9:0]    W_LIM    = 10'(NES_W);
    localparam logic [9:0]    H_LIM    = 10'(NES_H);
    localparam logic [AW-1:0] LAST_PTR = AW'(NES_W - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]    state;
    logic          bank_sel;   // bank currently shown (front)
    logic [AW-1:0] wr_ptr;
    logic [9:0]    q_y;

    // Both banks live in one array; the top address bit is the bank number.
    logic [5:0] mem [0:2*NES_W-1];

    logic       line_event;
    logic       wr_accept;
    logic       last_write;
    logic [9:0] next_y;
    logic [9:0] fill_target;

    assign line_event  = (nes_y_in != q_y);
    // A line change takes priority over a write arriving in the same cycle.
    assign wr_accept   = (state == ST_FILL) && wr_en_in && !line_event;
    assign last_write  = wr_accept && (wr_ptr == LAST_PTR);
    assign next_y      = nes_y_in + 10'd1;
    // Off-screen lines (and the last visible one) prefetch line 0.
    assign fill_target = (next_y < H_LIM) ? next_y : 10'd0;

    // Display read from the front bank; blank beyond the visible width.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        sys_palette_idx_out = 6'h00;
        if (nes_x_in < W_LIM) begin
            sys_palette_idx_out = mem[{bank_sel, nes_x_in[AW-1:0]}];
        end
    end

    // NOTE: storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk_in) begin
        if (wr_accept) begin
            mem[{~bank_sel, wr_ptr}] <= wr_idx_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: non-blocking assignments for all registered state.
            state         <= ST_IDLE;
            bank_sel      <= 1'b0;
            wr_ptr        <= '0;
            q_y           <= 10'd0;
            fill_req_out  <= 1'b0;
            fill_y_out    <= 10'd0;
            fill_busy_out <= 1'b0;
            underrun_out  <= 1'b0;
        end else begin
            q_y <= nes_y_in;

            // Set wins over clear.
            if (line_event && (state == ST_FILL)) begin
                underrun_out <= 1'b1;
            end else if (clr_underrun_in) begin
                underrun_out <= 1'b0;
            end

            if (line_event) begin
                bank_sel      <= ~bank_sel;
                state         <= ST_FILL;
                wr_ptr        <= '0;
                fill_req_out  <= 1'b1;
                fill_y_out    <= fill_target;
                fill_busy_out <= 1'b1;
            end else begin
                fill_req_out <= 1'b0;
                if (last_write) begin
                    // Pointer parks on the last pixel; nothing more is accepted.
                    state         <= ST_IDLE;
                    fill_busy_out <= 1'b0;
                end else if (wr_accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_line_buf.sv
// ---------------------------------------------------------------------------
// tb_ppu_line_buf
//
// Self-checking bench for ppu_line_buf. A line-level reference model keeps a
// displayed line and a line under construction, a count of pixels received
// and the request/underrun flags; it is stepped once per clock from the same
// inputs the DUT sees.
// ---------------------------------------------------------------------------
module tb_ppu_line_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] nes_x = 10'd0;
    logic [9:0] nes_y = 10'd0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_idx = 6'd0;
    logic       clr = 1'b0;
    logic [5:0] pal;
    logic       fill_req;
    logic [9:0] fill_y;
    logic       busy;
    logic       under;

    ppu_line_buf #(.NES_W(256), .NES_H(240)) dut (
        .clk_in              (clk),
        .rst_in              (rst),
        .nes_x_in            (nes_x),
        .nes_y_in            (nes_y),
        .wr_en_in            (wr_en),
        .wr_idx_in           (wr_idx),
        .clr_underrun_in     (clr),
        .sys_palette_idx_out (pal),
        .fill_req_out        (fill_req),
        .fill_y_out          (fill_y),
        .fill_busy_out       (busy),
        .underrun_out        (under)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model. Line contents of -1 mean "never written".
    bit m_req, m_busy, m_under;
    int m_fill_y, m_cnt, m_shown, m_last_y;
    int m_line [2][256];

    logic [12:0] dut_vec;
    assign dut_vec = {fill_req, fill_y, busy, under};

    function automatic logic [12:0] exp_vec();
        return {m_req, 10'(m_fill_y), m_busy, m_under};
    endfunction

    function automatic int exp_pix(input int x);
        if (x >= 256) return 0;
        return m_line[m_shown][x];
    endfunction

    task automatic model_reset();
        m_req = 0; m_busy = 0; m_under = 0;
        m_fill_y = 0; m_cnt = 0; m_shown = 0; m_last_y = 0;
    endtask

    task automatic model_step();
        int y;
        y = int'(nes_y);
        if (y != m_last_y) begin
            if (m_busy) m_under = 1;
            else if (clr) m_under = 0;
            m_shown  = 1 - m_shown;
            m_busy   = 1;
            m_cnt    = 0;
            m_req    = 1;
            m_fill_y = ((y + 1) % 1024 < 240) ? (y + 1) % 1024 : 0;
        end else begin
            m_req = 0;
            if (clr) m_under = 0;
            if (m_busy && wr_en) begin
                m_line[1 - m_shown][m_cnt] = int'(wr_idx);
                m_cnt++;
                if (m_cnt == 256) m_busy = 0;
            end
        end
        m_last_y = y;
    endtask

    // Advance one clock: model consumes the inputs present before the edge.
    task automatic tick();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] y, input logic we, input logic [5:0] idx,
                         input logic c);
        nes_y = y; wr_en = we; wr_idx = idx; clr = c;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; nes_y = 10'd0;
        tick(); tick();
        total++;
        if (dut_vec !== 13'd0) begin
            bad++; $display("FAIL reset_hold: got %h want %h", dut_vec, 13'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(10'd0, 1'b0, 6'd0, 1'b0);
            total++;
            if (dut_vec !== 13'd0) begin
                bad++; $display("FAIL reset_release: got %h want %h", dut_vec, 13'd0);
            end
        end
    endtask

    task automatic test_first_event();
        drive(10'h3FF, 1'b0, 6'd0, 1'b0);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL ev_3ff: got %h want %h", dut_vec, exp_vec());
        end
        drive(10'h000, 1'b0, 6'd0, 1'b0);
        total++;
        if ({fill_req, fill_y, busy} !== {1'b1, 10'd1, 1'b1}) begin
            bad++; $display("FAIL ev_to_0: got %h want %h", {fill_req, fill_y, busy}, {1'b1, 10'd1, 1'b1});
        end
        drive(10'h000, 1'b0, 6'd0, 1'b0);
        total++;
        if (fill_req !== 1'b0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL req_pulse_width: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    // Sweep the whole x range and compare the displayed pixel with the model.
    task automatic test_readback(input string name);
        int e;
        wr_en = 1'b0; clr = 1'b0;
        for (int x = 0; x < 640; x++) begin
            nes_x = 10'(x);
            tick();
            e = exp_pix(x);
            if (e >= 0) begin
                total++;
                if (pal !== 6'(e)) begin
                    bad++; $display("FAIL %s x=%0d: got %h want %h", name, x, pal, 6'(e));
                end
            end
        end
    endtask

    task automatic test_fill_display();
        drive(10'd5, 1'b0, 6'd0, 1'b1);   // clean underrun before the fill
        drive(10'd5, 1'b0, 6'd0, 1'b1);
        for (int x = 0; x < 256; x++) begin
            if ($urandom_range(0, 3) == 0) drive(10'd5, 1'b0, 6'd0, 1'b0);
            drive(10'd5, 1'b1, 6'(x % 64), 1'b0);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL fill_write %0d: got %h want %h", x, dut_vec, exp_vec());
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_after_256: got %b want 0", busy);
        end
        drive(10'd6, 1'b0, 6'd0, 1'b0);
        total++;
        if (under !== 1'b0 || fill_y !== 10'd7) begin
            bad++; $display("FAIL clean_swap: got %b/%0d want 0/7", under, fill_y);
        end
        // Explicit pattern, independent of the model.
        for (int x = 0; x < 640; x += 37) begin
            nes_x = 10'(x);
            drive(10'd6, 1'b0, 6'd0, 1'b0);
            total++;
            if (pal !== ((x < 256) ? 6'(x % 64) : 6'h00)) begin
                bad++; $display("FAIL pattern x=%0d: got %h want %h", x, pal,
                                (x < 256) ? 6'(x % 64) : 6'h00);
            end
        end
        test_readback("readback_mod64");
    endtask

    task automatic test_wrap_target();
        drive(10'd239, 1'b0, 6'd0, 1'b0);
        total++;
        if (fill_y !== 10'd0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL target_239: got %h want %h", dut_vec, exp_vec());
        end
        drive(10'd262, 1'b0, 6'd0, 1'b0);
        total++;
        if (fill_y !== 10'd0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL target_262: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_underrun();
        // Event while filling together with clear: set must win.
        drive(10'd20, 1'b0, 6'd0, 1'b1);
        total++;
        if (under !== 1'b1) begin
            bad++; $display("FAIL set_wins: got %b want 1", under);
        end
        drive(10'd20, 1'b0, 6'd0, 1'b1);
        total++;
        if (under !== 1'b0) begin
            bad++; $display("FAIL clear: got %b want 0", under);
        end
        for (int i = 0; i < 100; i++) drive(10'd20, 1'b1, 6'($urandom), 1'b0);
        drive(10'd21, 1'b0, 6'd0, 1'b0);
        total++;
        if ({fill_req, fill_y, busy, under} !== {1'b1, 10'd22, 1'b1, 1'b1}) begin
            bad++; $display("FAIL underrun_restart: got %h want %h", dut_vec,
                            {1'b1, 10'd22, 1'b1, 1'b1});
        end
        for (int i = 0; i < 256; i++) drive(10'd21, 1'b1, 6'($urandom), 1'b0);
        drive(10'd22, 1'b0, 6'd0, 1'b0);
        test_readback("readback_restart");
        drive(10'd22, 1'b0, 6'd0, 1'b1);
        total++;
        if (dut_vec !== exp_vec() || under !== 1'b0) begin
            bad++; $display("FAIL clr_pulse: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_collision();
        int first;
        drive(10'd29, 1'b0, 6'd0, 1'b1);
        drive(10'd30, 1'b1, 6'h2A, 1'b0);   // event and write together
        first = int'($urandom_range(0, 63));
        if (first == 42) first = 7;
        drive(10'd30, 1'b1, 6'(first), 1'b0);
        for (int i = 1; i < 257; i++) begin
            drive(10'd30, 1'b1, 6'($urandom), 1'b0);
            if (i == 255) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL busy_256th: got %b want 0", busy);
                end
            end
        end
        for (int i = 0; i < 5; i++) drive(10'd30, 1'b1, 6'h3F, 1'b0);   // idle writes
        drive(10'd31, 1'b0, 6'd0, 1'b0);
        nes_x = 10'd0;
        drive(10'd31, 1'b0, 6'd0, 1'b0);
        total++;
        if (pal !== 6'(first)) begin
            bad++; $display("FAIL collision_dropped: got %h want %h", pal, 6'(first));
        end
        test_readback("readback_257");
    endtask

    task automatic test_async_reset();
        drive(10'd40, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 50; i++) drive(10'd40, 1'b1, 6'($urandom), 1'b0);
        #4 rst = 1'b1;
        #2;
        total++;
        if (dut_vec !== 13'd0) begin
            bad++; $display("FAIL async_reset: got %h want %h", dut_vec, 13'd0);
        end
        nes_y = 10'd0; wr_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(10'd0, 1'b1, 6'h15, 1'b0);
            total++;
            if (dut_vec !== 13'd0) begin
                bad++; $display("FAIL no_event_after_reset: got %h want %h", dut_vec, 13'd0);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] y;
        int e;
        y = 10'd0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) y = 10'($urandom_range(0, 1023));
            nes_x = 10'($urandom_range(0, 639));
            drive(y, ($urandom_range(0, 3) != 0), 6'($urandom), ($urandom_range(0, 49) == 0));
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL rand_ctrl c=%0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (fill_y >= 10'd240) begin
                total++; bad++;
                $display("FAIL rand_fill_y_range c=%0d: got %0d want <240", c, fill_y);
            end
            e = exp_pix(int'(nes_x));
            if (e >= 0) begin
                total++;
                if (pal !== 6'(e)) begin
                    bad++; $display("FAIL rand_pix c=%0d x=%0d: got %h want %h", c, nes_x, pal, 6'(e));
                end
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < 256; x++) m_line[b][x] = -1;
        model_reset();
        test_reset();
        test_first_event();
        test_fill_display();
        test_wrap_target();
        test_underrun();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
